// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port RAM arbiter: FSM state codes and port IDs.
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_ACC  = 2'd1;
    localparam logic [1:0] ARB_WAIT = 2'd2;
    localparam logic [1:0] ARB_DONE = 2'd3;

    // Port IDs double as bit positions in the request vector given to arb_rr2.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin pick: a lone requester wins; on contention the port
// that did not win last time is chosen.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        if (req[PORT_CPU] && req[PORT_LD]) begin
            winner = ~last;
        end else if (req[PORT_LD]) begin
            winner = PORT_LD;
        end else begin
            winner = PORT_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU port and a loader port onto one single-port RAM with a
// fixed read latency of LAT cycles; one access in flight at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_ack,
    input  logic       ld_req,
    input  logic       ld_we,
    input  logic [7:0] ld_addr,
    input  logic [7:0] ld_wdata,
    output logic [7:0] ld_rdata,
    output logic       ld_ack,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    output logic       ram_re,
    input  logic [7:0] ram_rdata,
    output logic       busy
);

    localparam logic [1:0] WAIT_LAST = 2'(LAT - 1);

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       we_q, we_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] ram_addr_q, ram_addr_d;
    logic [7:0] ram_wdata_q, ram_wdata_d;
    logic [7:0] cpu_rdata_q, cpu_rdata_d;
    logic [7:0] ld_rdata_q, ld_rdata_d;
    logic       winner;

    arb_rr2 u_rr2 (
        .req    ({ld_req, cpu_req}),
        .last   (last_q),
        .winner (winner)
    );

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so that
        // no path through the case statement leaves one unassigned (no latches).
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        wait_cnt_d  = wait_cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (cpu_req || ld_req) begin
                    owner_d = winner;
                    last_d  = winner;
                    state_d = ARB_ACC;
                    if (winner == PORT_CPU) begin
                        we_d        = cpu_we;
                        ram_addr_d  = cpu_addr;
                        ram_wdata_d = cpu_wdata;
                    end else begin
                        we_d        = ld_we;
                        ram_addr_d  = ld_addr;
                        ram_wdata_d = ld_wdata;
                    end
                end
            end
            ARB_ACC: begin
                wait_cnt_d = 2'd0;
                state_d    = we_q ? ARB_DONE : ARB_WAIT;
            end
            ARB_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ARB_DONE;
                    if (owner_q == PORT_CPU) begin
                        cpu_rdata_d = ram_rdata;
                    end else begin
                        ld_rdata_d = ram_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the same pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= PORT_CPU;
            last_q      <= PORT_LD;
            we_q        <= 1'b0;
            wait_cnt_q  <= 2'd0;
            ram_addr_q  <= 8'h00;
            ram_wdata_q <= 8'h00;
            cpu_rdata_q <= 8'h00;
            ld_rdata_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            wait_cnt_q  <= wait_cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    assign ram_we    = (state_q == ARB_ACC) && we_q;
    assign ram_re    = (state_q == ARB_ACC) && !we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_ack   = (state_q == ARB_DONE) && (owner_q == PORT_CPU);
    assign ld_ack    = (state_q == ARB_DONE) && (owner_q == PORT_LD);
    assign cpu_rdata = cpu_rdata_q;
    assign ld_rdata  = ld_rdata_q;
    assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one LAT=1 instance for most scenarios and a
// LAT=3 instance for the long read; each models its RAM's read pipeline.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
    logic       ld_req = 1'b0, ld_we = 1'b0;
    logic [7:0] ld_addr = 8'h00, ld_wdata = 8'h00;
    logic [7:0] cpu_rdata, ld_rdata, ram_addr, ram_wdata;
    logic       cpu_ack, ld_ack, ram_we, ram_re, busy;
    logic [7:0] ram_rdata;

    logic       c3_req = 1'b0, c3_we = 1'b0;
    logic [7:0] c3_addr = 8'h00, c3_wdata = 8'h00;
    logic       l3_req = 1'b0, l3_we = 1'b0;
    logic [7:0] l3_addr = 8'h00, l3_wdata = 8'h00;
    logic [7:0] c3_rdata, l3_rdata, r3_addr, r3_wdata, r3_rdata;
    logic       c3_ack, l3_ack, r3_we, r3_re, busy3;

    logic [7:0] mem [256];
    logic [7:0] pipe1;
    logic [7:0] pipe3 [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LAT(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_arbiter #(.LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_rdata(c3_rdata), .cpu_ack(c3_ack),
        .ld_req(l3_req), .ld_we(l3_we), .ld_addr(l3_addr), .ld_wdata(l3_wdata),
        .ld_rdata(l3_rdata), .ld_ack(l3_ack),
        .ram_addr(r3_addr), .ram_wdata(r3_wdata), .ram_we(r3_we), .ram_re(r3_re),
        .ram_rdata(r3_rdata), .busy(busy3)
    );

    // RAM models: data appears LAT cycles after the read strobe, zero otherwise.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (r3_we) mem[r3_addr] <= r3_wdata;
        pipe1    <= ram_re ? mem[ram_addr] : 8'h00;
        pipe3[0] <= r3_re ? mem[r3_addr] : 8'h00;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign ram_rdata = pipe1;
    assign r3_rdata  = pipe3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks += 5;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if ({ram_we, ram_re} !== 2'b00) begin n_errors++; $display("FAIL reset_strobes: got %b want 00", {ram_we, ram_re}); end
        if ({cpu_ack, ld_ack} !== 2'b00) begin n_errors++; $display("FAIL reset_acks: got %b want 00", {cpu_ack, ld_ack}); end
        if ({ram_addr, ram_wdata} !== 16'h0000) begin n_errors++; $display("FAIL reset_ram_bus: got %h want 0000", {ram_addr, ram_wdata}); end
        if ({cpu_rdata, ld_rdata} !== 16'h0000) begin n_errors++; $display("FAIL reset_rdata: got %h want 0000", {cpu_rdata, ld_rdata}); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ld_write();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h10; ld_wdata = 8'hA5;
        n_checks++;
        if ({ram_we, busy} !== 2'b00) begin n_errors++; $display("FAIL ldw_t0: got %b want 00", {ram_we, busy}); end
        tick();
        n_checks += 3;
        if ({ram_we, ram_re, busy} !== 3'b101) begin n_errors++; $display("FAIL ldw_t1_strobes: got %b want 101", {ram_we, ram_re, busy}); end
        if ({ram_addr, ram_wdata} !== 16'h10A5) begin n_errors++; $display("FAIL ldw_t1_bus: got %h want 10a5", {ram_addr, ram_wdata}); end
        if (ld_ack !== 1'b0) begin n_errors++; $display("FAIL ldw_t1_ack: got %b want 0", ld_ack); end
        tick();
        n_checks += 2;
        if ({ld_ack, cpu_ack} !== 2'b10) begin n_errors++; $display("FAIL ldw_t2_acks: got %b want 10", {ld_ack, cpu_ack}); end
        if (ram_we !== 1'b0) begin n_errors++; $display("FAIL ldw_t2_we: got %b want 0", ram_we); end
        ld_req = 1'b0;
        tick();
        n_checks += 2;
        if ({ld_ack, busy} !== 2'b00) begin n_errors++; $display("FAIL ldw_t3_idle: got %b want 00", {ld_ack, busy}); end
        if ({ram_addr, ram_wdata} !== 16'h10A5) begin n_errors++; $display("FAIL ldw_t3_hold: got %h want 10a5", {ram_addr, ram_wdata}); end
    endtask

    // Request dropped right after capture: the write still completes and acks.
    task automatic test_cpu_write_drop();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h3C;
        tick();
        cpu_req = 1'b0;
        n_checks++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 16'h203C}) begin
            n_errors++; $display("FAIL cpuw_t1: got %h want 1203c", {ram_we, ram_addr, ram_wdata});
        end
        tick();
        n_checks++;
        if ({cpu_ack, ld_ack} !== 2'b10) begin n_errors++; $display("FAIL cpuw_t2_ack: got %b want 10", {cpu_ack, ld_ack}); end
        tick();
        n_checks++;
        if ({cpu_ack, busy} !== 2'b00) begin n_errors++; $display("FAIL cpuw_t3_idle: got %b want 00", {cpu_ack, busy}); end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        tick();
        n_checks++;
        if ({ram_re, ram_we, ram_addr} !== {2'b10, 8'h20}) begin
            n_errors++; $display("FAIL cpur_t1: got %h want 220", {ram_re, ram_we, ram_addr});
        end
        tick();
        n_checks++;
        if ({busy, cpu_ack, ram_re} !== 3'b100) begin n_errors++; $display("FAIL cpur_t2_wait: got %b want 100", {busy, cpu_ack, ram_re}); end
        tick();
        n_checks += 2;
        if ({cpu_ack, ld_ack} !== 2'b10) begin n_errors++; $display("FAIL cpur_t3_ack: got %b want 10", {cpu_ack, ld_ack}); end
        if (cpu_rdata !== 8'h3C) begin n_errors++; $display("FAIL cpur_t3_rdata: got %h want 3c", cpu_rdata); end
        cpu_req = 1'b0;
        tick();
        n_checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b0, 8'h3C}) begin n_errors++; $display("FAIL cpur_t4_hold: got %h want 03c", {cpu_ack, cpu_rdata}); end
    endtask

    task automatic test_ld_read();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h10;
        tick();
        tick();
        tick();
        n_checks += 2;
        if ({ld_ack, ld_rdata} !== {1'b1, 8'hA5}) begin n_errors++; $display("FAIL ldr_t3: got %h want 1a5", {ld_ack, ld_rdata}); end
        if (cpu_rdata !== 8'h3C) begin n_errors++; $display("FAIL ldr_cpu_hold: got %h want 3c", cpu_rdata); end
        ld_req = 1'b0;
        tick();
    endtask

    task automatic test_req_pulse();
        int cpu_acks = 0;
        int writes = 0;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h70; ld_wdata = 8'h5A;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h60; cpu_wdata = 8'h77;
        tick();
        cpu_req = 1'b0;
        n_checks++;
        if (ld_ack !== 1'b1) begin n_errors++; $display("FAIL pulse_ld_ack: got %b want 1", ld_ack); end
        ld_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_ack) cpu_acks++;
            if (ram_we || ram_re) writes++;
        end
        n_checks++;
        if ({cpu_acks, writes} !== {32'd0, 32'd0}) begin
            n_errors++; $display("FAIL pulse_no_access: got acks=%0d accesses=%0d want 0/0", cpu_acks, writes);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] order = 4'b0000;
        int         ngrant = 0;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 8'h11;
        ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 8'h50; ld_wdata  = 8'h22;
        for (int i = 0; i < 40 && ngrant < 4; i++) begin
            tick();
            if (ram_we) begin
                order[ngrant] = (ram_addr == 8'h50);
                ngrant++;
            end
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        n_checks += 2;
        if (ngrant !== 4) begin n_errors++; $display("FAIL b2b_grant_count: got %0d want 4", ngrant); end
        // bit i = 1 means loader won grant i: expect CPU, LD, CPU, LD
        if (order !== 4'b1010) begin n_errors++; $display("FAIL b2b_order: got %b want 1010", order); end
        tick(); tick(); tick();
        n_checks++;
        if ({busy, cpu_rdata, ld_rdata} !== 17'h0) begin
            n_errors++; $display("FAIL b2b_rdata_untouched: got %h want 00000", {busy, cpu_rdata, ld_rdata});
        end
    endtask

    task automatic test_reset_in_wait();
        int acks = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        tick();
        tick();
        n_checks++;
        if ({busy, ram_re} !== 2'b10) begin n_errors++; $display("FAIL rst_wait_pre: got %b want 10", {busy, ram_re}); end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, ram_we, ram_re, cpu_ack, ld_ack} !== 5'b0) begin
            n_errors++; $display("FAIL rst_wait_immediate: got %b want 00000", {busy, ram_we, ram_re, cpu_ack, ld_ack});
        end
        cpu_req = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_ack || ld_ack) acks++;
        end
        n_checks++;
        if (acks !== 0) begin n_errors++; $display("FAIL rst_wait_no_ack: got %0d acks want 0", acks); end
    endtask

    task automatic test_lat3_read();
        int re_cyc = 0;
        int waits = 0;
        int ack_cyc = 0;
        logic [7:0] rd = 8'h00;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'hC7;
        tick(); tick();
        cpu_req = 1'b0;
        tick();
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = 8'h30;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (r3_re) re_cyc = k;
            if (busy3 && !r3_re && !c3_ack) waits++;
            if (c3_ack && ack_cyc == 0) begin
                ack_cyc = k;
                rd = c3_rdata;
                c3_req = 1'b0;
            end
        end
        c3_req = 1'b0;
        n_checks += 4;
        if (re_cyc !== 1) begin n_errors++; $display("FAIL lat3_acc_cycle: got %0d want 1", re_cyc); end
        if (waits !== 3) begin n_errors++; $display("FAIL lat3_wait_cycles: got %0d want 3", waits); end
        if (ack_cyc !== 5) begin n_errors++; $display("FAIL lat3_ack_cycle: got %0d want 5", ack_cyc); end
        if (rd !== 8'hC7) begin n_errors++; $display("FAIL lat3_rdata: got %h want c7", rd); end
    endtask

    initial begin
        test_reset();
        test_ld_write();
        test_cpu_write_drop();
        test_cpu_read();
        test_ld_read();
        test_req_pulse();
        test_back_to_back();
        test_reset_in_wait();
        test_lat3_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
